// File: rtl/cacheline_arbiter_pkg.sv
// Shared types for the I/D cacheline arbiter: FSM states and transaction owner.
package arbiter_types;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    DONE    = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } arb_owner_t;

  function automatic arb_owner_t other_owner(input arb_owner_t o);
    return (o == OWNER_D) ? OWNER_I : OWNER_D;
  endfunction

endpackage

// File: rtl/cacheline_arbiter_grant_sel.sv
// Grant select for the cacheline arbiter. Fixed D-side priority by default;
// round-robin with a pointer flop when CACHELINE_ARB_RR_EN is defined.
module arb_grant_sel
  import arbiter_types::*;
(
`ifdef CACHELINE_ARB_RR_EN
  input  logic       clk,
  input  logic       rst,
  input  logic       i_take,
`endif
  input  logic       i_req_i,
  input  logic       i_req_d,
  output arb_owner_t o_owner,
  output logic       o_any
);

  assign o_any = i_req_i | i_req_d;

`ifdef CACHELINE_ARB_RR_EN
  // r_prio names the side that wins a tie; it flips away from every winner.
  arb_owner_t r_prio;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_prio <= OWNER_D;
    end else if (i_take && o_any) begin
      r_prio <= other_owner(o_owner);
    end
  end

  always_comb begin
    o_owner = OWNER_I;
    if (i_req_i && i_req_d) begin
      o_owner = r_prio;
    end else if (i_req_d) begin
      o_owner = OWNER_D;
    end
  end
`else
  always_comb begin
    o_owner = i_req_d ? OWNER_D : OWNER_I;
  end
`endif

endmodule

// File: rtl/cacheline_arbiter.sv
// Shares one memory cacheline port between I-cache and D-cache miss paths.
// Round-robin grant when CACHELINE_ARB_RR_EN is defined, else fixed D priority.
module cacheline_arbiter
  import arbiter_types::*;
#(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              icache_pmem_read,
  input  logic [ADDR_W-1:0] icache_pmem_address,
  output logic [LINE_W-1:0] icache_pmem_rdata,
  output logic              icache_pmem_resp,
  input  logic              dcache_pmem_read,
  input  logic              dcache_pmem_write,
  input  logic [ADDR_W-1:0] dcache_pmem_address,
  input  logic [LINE_W-1:0] dcache_pmem_wdata,
  output logic [LINE_W-1:0] dcache_pmem_rdata,
  output logic              dcache_pmem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  arb_owner_t        w_win;
  logic              w_any;
  logic              w_d_req;
  logic              w_grant;
  logic              w_d_wr;
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_wdata;
  logic              r_write;

  assign w_d_req = dcache_pmem_read | dcache_pmem_write;
  assign w_d_wr  = dcache_pmem_write;
  assign w_grant = (r_state == IDLE) && w_any;

  arb_grant_sel u_grant_sel (
`ifdef CACHELINE_ARB_RR_EN
    .clk     (clk),
    .rst     (rst),
    .i_take  (w_grant),
`endif
    .i_req_i (icache_pmem_read),
    .i_req_d (w_d_req),
    .o_owner (w_win),
    .o_any   (w_any)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Latched request: the memory side never follows the requester inputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_write <= 1'b0;
    end else if (w_grant) begin
      if (w_win == OWNER_D) begin
        r_addr  <= dcache_pmem_address;
        r_wdata <= w_d_wr ? dcache_pmem_wdata : '0;
        r_write <= w_d_wr;
      end else begin
        r_addr  <= icache_pmem_address;
        r_wdata <= '0;
        r_write <= 1'b0;
      end
    end
  end

  assign pmem_address = r_addr;
  assign pmem_wdata   = r_wdata;

  always_comb begin
    w_state_nxt       = r_state;
    pmem_read         = 1'b0;
    pmem_write        = 1'b0;
    icache_pmem_resp  = 1'b0;
    dcache_pmem_resp  = 1'b0;
    icache_pmem_rdata = '0;
    dcache_pmem_rdata = '0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt = (w_win == OWNER_D) ? GRANT_D : GRANT_I;
        end
      end
      GRANT_I: begin
        pmem_read = 1'b1;
        // Response is gated by reset so an abandoned transaction never completes.
        if (pmem_resp && rst) begin
          icache_pmem_resp  = 1'b1;
          icache_pmem_rdata = pmem_rdata;
        end
        if (pmem_resp) begin
          w_state_nxt = DONE;
        end
      end
      GRANT_D: begin
        pmem_read  = !r_write;
        pmem_write = r_write;
        if (pmem_resp && rst) begin
          dcache_pmem_resp  = 1'b1;
          dcache_pmem_rdata = pmem_rdata;
        end
        if (pmem_resp) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        // Bubble so a request still held through the resp cycle is not regranted.
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  a_dcache_rw_exclusive: assert property (
    @(posedge clk) disable iff (!rst) !(dcache_pmem_read && dcache_pmem_write)
  );

endmodule

// File: doc/cacheline_arbiter.md
# cacheline_arbiter

Shares the single physical-memory cacheline port between the instruction-cache and data-cache miss paths of the pipelined RV32I core. It sits between the two caches and the memory/L2 interface, accepts at most one line transaction at a time, latches the winner's request, and routes the response back to the owner. Grant policy is fixed data-side priority, or round-robin when configured.

## Interface
- `LINE_W`, default 256: cacheline width in bits.
- `ADDR_W`, default 32: line address width.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-low reset (asserted when 0, sampled on `clk`).
- `icache_pmem_read`  in  1  I-side line-read request; held until `icache_pmem_resp`.
- `icache_pmem_address`  in  ADDR_W  I-side line address.
- `icache_pmem_rdata`  out  LINE_W  line data to I-cache.
- `icache_pmem_resp`  out  1  one-cycle completion pulse to I-cache.
- `dcache_pmem_read`  in  1  D-side line-read request.
- `dcache_pmem_write`  in  1  D-side line-writeback request.
- `dcache_pmem_address`  in  ADDR_W  D-side line address.
- `dcache_pmem_wdata`  in  LINE_W  D-side writeback line.
- `dcache_pmem_rdata`  out  LINE_W  line data to D-cache.
- `dcache_pmem_resp`  out  1  one-cycle completion pulse to D-cache.
- `pmem_read`, `pmem_write`  out  1  memory command, held until `pmem_resp`.
- `pmem_address`  out  ADDR_W  latched line address.
- `pmem_wdata`  out  LINE_W  latched writeback data.
- `pmem_rdata`  in  LINE_W  memory read data, valid with `pmem_resp`.
- `pmem_resp`  in  1  memory completion, one cycle.

## Operation
- FSM states: IDLE, GRANT_I, GRANT_D, DONE.
- IDLE: if any request is pending, grant per policy; latch owner's address, wdata, and op into registers; next state GRANT_I/GRANT_D.
- GRANT_x: `pmem_read`/`pmem_write` driven from latched op; address and wdata come from latches and do not follow requester inputs. On `pmem_resp`: pulse owner's `*_resp`, forward `pmem_rdata` to the owner's rdata, clear command, go to DONE.
- DONE: one bubble cycle, no grant. This prevents a request held through the resp cycle from being granted again. Next state is IDLE.
- D-side read and write asserted together is illegal; write wins, and an assertion fires in simulation.
- Non-owner `*_resp` is always 0. Rdata outputs are 0 except the owner's during the resp cycle.
- Default policy: D-side wins whenever both request in IDLE.

## Timing
- Reset values: all outputs 0, state IDLE, latches 0, round-robin pointer to D.
- Request seen in IDLE at cycle t produces `pmem_read`/`pmem_write` high from cycle t+1.
- `pmem_resp` at cycle r produces `*_resp` at cycle r, combinational pass-through gated by registered owner. The command drops at r+1; r+1 is DONE and r+2 is IDLE.
- Minimum back-to-back spacing is 3 cycles from grant to next grant, plus memory latency.
- `pmem_resp` in IDLE or DONE is ignored.
- Reset mid-transaction abandons it: no resp to either cache, command drops next cycle. The memory model must tolerate this.

## Configuration
- `CACHELINE_ARB_RR_EN` defined: round-robin. When both request in IDLE, grant the side not served last. The pointer updates on each grant.
- Undefined: fixed D-priority and no pointer register. I-side starvation under continuous D traffic is accepted.

## Structure
- Shared package `arbiter_types` holds the `arb_state_t` enum (IDLE, GRANT_I, GRANT_D, DONE) and the `arb_owner_t` enum (OWNER_I, OWNER_D).
- The grant decision is a natural sub-module, `arb_grant_sel`: combinational select plus optional round-robin pointer flop.
- The FSM, latches, and response routing stay in the top.

## Test plan
- I-read only, addr 0x0000_0040, memory latency 5. Required: `pmem_read` high from t+1, `icache_pmem_resp` pulses once, rdata matches the model line, D outputs stay 0.
- D-write, addr 0x0000_1000, wdata pattern 0xA5…. Required: `pmem_write` high, `pmem_wdata` stable even when the D input changes mid-transaction, `dcache_pmem_resp` pulses once.
- Simultaneous I-read 0x40 and D-read 0x80 held continuously:
  - Default: D served first, then I.
  - With `CACHELINE_ARB_RR_EN`: grants alternate D,I,D,I over 4 transactions.
- Requester keeps request high through resp cycle. Required: no duplicate grant, DONE bubble observed, at most 1 `pmem` transaction per request.
- Reset (`rst`=0) two cycles into a D-read. Required: next cycle all outputs 0, no resp pulse, and a fresh I-read afterwards completes normally.
